// File: rtl/hub75_scan_ctrl.sv
// HUB75 row/bit-plane scan sequencer: row preload/swap, column streaming, latch and BCM blanking.
// Optional anti-ghosting blank guard after each SHOW: define HUB75_SCAN_GHOST_GUARD_EN.
module hub75_scan_ctrl #(
  parameter int N_ROWS       = 32,
  parameter int N_COLS       = 64,
  parameter int N_PLANES     = 8,
  parameter int GUARD_CYCLES = 4,
  parameter int LOG_N_ROWS   = $clog2(N_ROWS),
  parameter int LOG_N_COLS   = $clog2(N_COLS),
  parameter int LOG_N_PLANES = $clog2(N_PLANES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ctrl_run,
  input  logic [7:0]              cfg_bcm_lsb,
  output logic [LOG_N_ROWS-1:0]   rd_row_addr,
  output logic                    rd_row_load,
  input  logic                    rd_row_rdy,
  output logic                    rd_row_swap,
  output logic [LOG_N_COLS-1:0]   rd_col_addr,
  output logic                    rd_en,
  output logic                    sh_valid,
  output logic [LOG_N_PLANES-1:0] sh_plane,
  output logic [LOG_N_ROWS-1:0]   phy_addr,
  output logic                    phy_le,
  output logic                    phy_blank,
  output logic                    frame_start
);

  localparam int TW = 8 + N_PLANES - 1;

  typedef enum logic [3:0] {
    S_IDLE, S_PRIME, S_SWAP, S_SHIFT, S_SETTLE, S_LATCH, S_SHOW, S_GUARD, S_NEXT, S_DRAIN
  } state_t;

  state_t                  r_state;
  logic [LOG_N_ROWS-1:0]   r_cur_row;
  logic [LOG_N_PLANES-1:0] r_plane;
  logic [TW-1:0]           r_timer;
  logic                    r_settle;
  logic [LOG_N_ROWS-1:0]   r_rd_row_addr;
  logic                    r_rd_row_load;
  logic                    r_rd_row_swap;
  logic [LOG_N_COLS-1:0]   r_rd_col_addr;
  logic                    r_rd_en;
  logic                    r_sh_valid;
  logic [LOG_N_PLANES-1:0] r_sh_plane;
  logic [LOG_N_ROWS-1:0]   r_phy_addr;
  logic                    r_phy_le;
  logic                    r_phy_blank;
  logic                    r_frame_start;
`ifdef HUB75_SCAN_GHOST_GUARD_EN
  localparam int GW = $clog2(GUARD_CYCLES + 1);
  logic [GW-1:0]           r_guard;
`endif

  logic [LOG_N_ROWS-1:0] w_row_inc;
  logic                  w_last_plane;
  logic [7:0]            w_lsb;
  logic [TW-1:0]         w_show_len;

  assign w_row_inc    = (r_cur_row == LOG_N_ROWS'(N_ROWS - 1)) ? '0 : r_cur_row + 1'b1;
  assign w_last_plane = (r_plane == LOG_N_PLANES'(N_PLANES - 1));
  assign w_lsb        = (cfg_bcm_lsb == 8'd0) ? 8'd1 : cfg_bcm_lsb;
  assign w_show_len   = TW'(w_lsb) << r_plane;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_cur_row     <= '0;
      r_plane       <= '0;
      r_timer       <= '0;
      r_settle      <= 1'b0;
      r_rd_row_addr <= '0;
      r_rd_row_load <= 1'b0;
      r_rd_row_swap <= 1'b0;
      r_rd_col_addr <= '0;
      r_rd_en       <= 1'b0;
      r_sh_valid    <= 1'b0;
      r_sh_plane    <= '0;
      r_phy_addr    <= '0;
      r_phy_le      <= 1'b0;
      r_phy_blank   <= 1'b1;
      r_frame_start <= 1'b0;
`ifdef HUB75_SCAN_GHOST_GUARD_EN
      r_guard       <= '0;
`endif
    end else begin
      r_rd_row_load <= 1'b0;
      r_rd_row_swap <= 1'b0;
      r_frame_start <= 1'b0;
      r_phy_le      <= 1'b0;
      r_sh_valid    <= r_rd_en;
      r_sh_plane    <= r_plane;
      case (r_state)
        S_IDLE: begin
          if (ctrl_run) begin
            r_rd_row_load <= 1'b1;
            r_rd_row_addr <= '0;
            r_state       <= S_PRIME;
          end
        end
        // rdy seen during the load cycle is stale (previous buffer), so ignore it there.
        S_PRIME: begin
          if (rd_row_rdy && !r_rd_row_load) begin
            r_rd_row_swap <= 1'b1;
            r_rd_row_load <= 1'b1;
            r_rd_row_addr <= w_row_inc;
            r_state       <= S_SWAP;
          end
        end
        S_SWAP: begin
          r_plane       <= '0;
          r_rd_en       <= 1'b1;
          r_rd_col_addr <= '0;
          r_frame_start <= (r_cur_row == '0);
          r_state       <= S_SHIFT;
        end
        S_SHIFT: begin
          if (r_rd_col_addr == LOG_N_COLS'(N_COLS - 1)) begin
            r_rd_en  <= 1'b0;
            r_settle <= 1'b0;
            r_state  <= S_SETTLE;
          end else begin
            r_rd_col_addr <= r_rd_col_addr + 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_settle) begin
            r_phy_le   <= 1'b1;
            r_phy_addr <= r_cur_row;
            r_state    <= S_LATCH;
          end else begin
            r_settle <= 1'b1;
          end
        end
        S_LATCH: begin
          r_phy_blank <= 1'b0;
          r_timer     <= w_show_len;
          r_state     <= S_SHOW;
        end
        S_SHOW: begin
          if (r_timer == TW'(1)) begin
            r_phy_blank <= 1'b1;
`ifdef HUB75_SCAN_GHOST_GUARD_EN
            r_guard     <= GW'(GUARD_CYCLES);
            r_state     <= S_GUARD;
`else
            if (!w_last_plane) begin
              r_plane       <= r_plane + 1'b1;
              r_rd_en       <= 1'b1;
              r_rd_col_addr <= '0;
              r_state       <= S_SHIFT;
            end else begin
              r_cur_row <= w_row_inc;
              r_state   <= S_NEXT;
            end
`endif
          end else begin
            r_timer <= r_timer - 1'b1;
          end
        end
`ifdef HUB75_SCAN_GHOST_GUARD_EN
        S_GUARD: begin
          if (r_guard <= GW'(1)) begin
            if (!w_last_plane) begin
              r_plane       <= r_plane + 1'b1;
              r_rd_en       <= 1'b1;
              r_rd_col_addr <= '0;
              r_state       <= S_SHIFT;
            end else begin
              r_cur_row <= w_row_inc;
              r_state   <= S_NEXT;
            end
          end else begin
            r_guard <= r_guard - 1'b1;
          end
        end
`endif
        S_NEXT: begin
          if (!ctrl_run) begin
            r_state <= S_DRAIN;
          end else if (rd_row_rdy) begin
            r_rd_row_swap <= 1'b1;
            r_rd_row_load <= 1'b1;
            r_rd_row_addr <= w_row_inc;
            r_state       <= S_SWAP;
          end
        end
        S_DRAIN: begin
          if (rd_row_rdy) begin
            r_cur_row <= '0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rd_row_addr = r_rd_row_addr;
  assign rd_row_load = r_rd_row_load;
  assign rd_row_swap = r_rd_row_swap;
  assign rd_col_addr = r_rd_col_addr;
  assign rd_en       = r_rd_en;
  assign sh_valid    = r_sh_valid;
  assign sh_plane    = r_sh_plane;
  assign phy_addr    = r_phy_addr;
  assign phy_le      = r_phy_le;
  assign phy_blank   = r_phy_blank;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: cycle schedule model derived from plane/row timing rules, plus a readout model.
module tb_hub75_scan_ctrl;
  localparam int NR = 4;
  localparam int NC = 4;
  localparam int NP = 2;
  localparam int GC = 4;
`ifdef HUB75_SCAN_GHOST_GUARD_EN
  localparam int G = GC;
`else
  localparam int G = 0;
`endif
  localparam int M_IDLE = 0, M_PRIME = 1, M_RUN = 2, M_NEXT = 3, M_DRAIN = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ctrl_run = 1'b0;
  logic [7:0] cfg_bcm_lsb = 8'd3;
  logic       rd_row_rdy = 1'b0;
  logic [1:0] rd_row_addr, rd_col_addr, phy_addr;
  logic       rd_row_load, rd_row_swap, rd_en, sh_valid, phy_le, phy_blank, frame_start;
  logic [0:0] sh_plane;

  hub75_scan_ctrl #(.N_ROWS(NR), .N_COLS(NC), .N_PLANES(NP), .GUARD_CYCLES(GC)) dut (
    .clk(clk), .rst(rst), .ctrl_run(ctrl_run), .cfg_bcm_lsb(cfg_bcm_lsb),
    .rd_row_addr(rd_row_addr), .rd_row_load(rd_row_load), .rd_row_rdy(rd_row_rdy),
    .rd_row_swap(rd_row_swap), .rd_col_addr(rd_col_addr), .rd_en(rd_en),
    .sh_valid(sh_valid), .sh_plane(sh_plane), .phy_addr(phy_addr), .phy_le(phy_le),
    .phy_blank(phy_blank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // Readout model: rdy drops on a load and rises lat cycles later, staying high until the next load.
  int lat = 5;
  int rd_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      rd_row_rdy <= 1'b0;
      rd_cnt     <= 0;
    end else if (rd_row_load) begin
      rd_row_rdy <= 1'b0;
      rd_cnt     <= lat;
    end else if (rd_cnt != 0) begin
      rd_cnt <= rd_cnt - 1;
      if (rd_cnt == 1) rd_row_rdy <= 1'b1;
    end
  end

  int n_vec = 0, n_bad = 0;
  logic rst_nx = 1'b0, run_nx = 1'b1;
  logic [7:0] cfg_nx = 8'd3;
  bit valid = 0;
  int kcnt = 0;
  int mode = M_IDLE, row = 0, plane = 0, b = 0, S = 1, wait_from = 0;
  int e_load = 0, e_load_addr = 0, e_swap = 0, e_rd_en = 0, e_col = 0, e_shv = 0, e_shp = 0;
  int e_le = 0, e_addr = 0, e_blank = 1, e_fs = 0;
  int le_q[$];
  int ld_q[$];
  int fs_cnt = 0, sw_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_swap(input int nk);
    e_swap = 1; e_load = 1; e_load_addr = (row + 1) % NR;
    mode = M_RUN; plane = 0; b = nk + 1;
  endtask

  // Predicts the outputs of the next cycle from the inputs the DUT samples at the coming edge.
  task automatic model_step();
    int nk, o, shp, shv;
    nk = kcnt + 1;
    shv = e_rd_en; shp = plane;
    e_load = 0; e_swap = 0; e_rd_en = 0; e_le = 0; e_fs = 0; e_blank = 1;
    if (!rst) begin
      mode = M_IDLE; row = 0; plane = 0; e_addr = 0; e_shv = 0; e_shp = 0; valid = 1;
      return;
    end
    e_shv = shv; e_shp = shp;
    case (mode)
      M_IDLE:  if (ctrl_run) begin e_load = 1; e_load_addr = 0; mode = M_PRIME; wait_from = nk + 1; end
      M_PRIME: if (kcnt >= wait_from && rd_row_rdy) start_swap(nk);
      M_NEXT:  if (!ctrl_run) mode = M_DRAIN; else if (rd_row_rdy) start_swap(nk);
      M_DRAIN: if (rd_row_rdy) begin mode = M_IDLE; row = 0; end
      default: begin
        o = nk - b;
        if (o == NC + 3 + S + G) begin
          if (plane < NP - 1) begin plane++; b = nk; o = 0; end
          else begin mode = M_NEXT; row = (row + 1) % NR; end
        end
        if (mode == M_RUN) begin
          if (o < NC) begin e_rd_en = 1; e_col = o; e_fs = (o == 0 && row == 0 && plane == 0) ? 1 : 0; end
          if (o == NC + 2) begin e_le = 1; e_addr = row; end
          if (o == NC + 3) S = ((cfg_bcm_lsb == 8'd0) ? 1 : int'(cfg_bcm_lsb)) << plane;
          if (o >= NC + 3 && o < NC + 3 + S) e_blank = 0;
        end
      end
    endcase
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (valid) begin
        chk("rd_row_load", rd_row_load, e_load);
        if (e_load != 0) chk("rd_row_addr", rd_row_addr, e_load_addr);
        chk("rd_row_swap", rd_row_swap, e_swap);
        chk("rd_en", rd_en, e_rd_en);
        if (e_rd_en != 0) chk("rd_col_addr", rd_col_addr, e_col);
        chk("sh_valid", sh_valid, e_shv);
        if (e_shv != 0) chk("sh_plane", sh_plane, e_shp);
        chk("phy_le", phy_le, e_le);
        chk("phy_blank", phy_blank, e_blank);
        chk("frame_start", frame_start, e_fs);
        chk("phy_addr", phy_addr, e_addr);
        if (phy_le === 1'b1) le_q.push_back(int'(phy_addr));
        if (rd_row_load === 1'b1) ld_q.push_back(int'(rd_row_addr));
        if (frame_start === 1'b1) fs_cnt++;
        if (rd_row_swap === 1'b1) sw_cnt++;
      end
      rst = rst_nx; ctrl_run = run_nx; cfg_bcm_lsb = cfg_nx;
      model_step();
      kcnt++;
    end
  endtask

  initial begin
    int found;
    // Reset held with ctrl_run high.
    rst_nx = 1'b0; run_nx = 1'b1; cfg_nx = 8'd3; lat = 5;
    cyc(4);
    // Startup and row wrap over five rows.
    le_q.delete(); ld_q.delete(); fs_cnt = 0;
    rst_nx = 1'b1;
    cyc(135);
    for (int i = 0; i < 10; i++) chk("latch_row_seq", (i < le_q.size()) ? le_q[i] : -1, (i / 2) % NR);
    for (int i = 0; i < 6; i++) chk("load_row_seq", (i < ld_q.size()) ? ld_q[i] : -1, i % NR);
    chk("frame_start_count", fs_cnt, 2);
    // Stall at a row boundary with a slow preload.
    lat = 45;
    cyc(40);
    lat = 5;
    cyc(60);
    // Stop mid-SHOW of row 2.
    found = 0;
    for (int i = 0; i < 300; i++) begin
      cyc(1);
      if (phy_blank === 1'b0 && phy_addr === 2'd2) begin found = 1; break; end
    end
    chk("wait_row2_show", found, 1);
    run_nx = 1'b0;
    cyc(2);
    ld_q.delete(); sw_cnt = 0;
    cyc(60);
    chk("drain_no_load", ld_q.size(), 0);
    chk("drain_no_swap", sw_cnt, 0);
    // Restart from row 0.
    ld_q.delete(); fs_cnt = 0;
    run_nx = 1'b1;
    cyc(40);
    chk("restart_load_row", (ld_q.size() > 0) ? ld_q[0] : -1, 0);
    chk("restart_frame_start", fs_cnt, 1);
    // Randomized run/stop, BCM base, preload latency and one mid-operation reset.
    for (int it = 0; it < 12; it++) begin
      cfg_nx = 8'($urandom_range(0, 5));
      lat = $urandom_range(2, 50);
      run_nx = ($urandom_range(0, 3) != 0);
      if (it == 6) begin
        rst_nx = 1'b0; cyc(2); rst_nx = 1'b1;
      end
      cyc($urandom_range(20, 90));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/hub75_scan_ctrl.md
# hub75_scan_ctrl

Row/plane scan sequencer for the HUB75 panel driver. Sits directly upstream of the frame-buffer readout: it requests row preloads, swaps the readout's double line buffer, and streams column addresses out of it. In parallel it drives the panel row address, latch and blanking with binary-weighted (BCM) on-times per bit plane. The downstream shifter consumes `rd_data` qualified by `sh_valid` and `sh_plane`.

## Interface
- `N_ROWS`, 32: rows per bank (scan lines).
- `N_COLS`, 64: columns per row.
- `N_PLANES`, 8: bit planes per channel.
- `GUARD_CYCLES`, 4: anti-ghosting blank guard length (used only with the macro).
- `LOG_N_ROWS`, `LOG_N_COLS`, `LOG_N_PLANES`: auto-set, `$clog2` of the above.

Ports:
- `clk` in 1: clock, single domain.
- `rst` in 1: synchronous, active-low reset.
- `ctrl_run` in 1: enable scanning.
- `cfg_bcm_lsb` in 8: on-time of plane 0, in clk cycles. 0 is treated as 1.
- `rd_row_addr` out LOG_N_ROWS: row to preload.
- `rd_row_load` out 1: 1-cycle preload request.
- `rd_row_rdy` in 1: preload complete, back buffer valid.
- `rd_row_swap` out 1: 1-cycle buffer swap.
- `rd_col_addr` out LOG_N_COLS: column read address.
- `rd_en` out 1: column read strobe.
- `sh_valid` out 1: `rd_data` valid this cycle; equals `rd_en` delayed 1 cycle.
- `sh_plane` out LOG_N_PLANES: plane to extract from `rd_data`; aligned with `sh_valid`.
- `phy_addr` out LOG_N_ROWS: panel row address.
- `phy_le` out 1: panel latch.
- `phy_blank` out 1: panel output-enable, active high (1 = dark).
- `frame_start` out 1: 1-cycle pulse when row 0, plane 0 begins shifting.

## Operation
- All outputs are registered.
- Reset values:
  - `phy_blank`=1.
  - All other outputs 0.
  - State IDLE, `cur_row`=0, `plane`=0.
- FSM states: IDLE, PRIME, SWAP, SHIFT, SETTLE, LATCH, SHOW, GUARD, NEXT, DRAIN.
- IDLE:
  - Hold `phy_blank`=1.
  - When `ctrl_run`=1: pulse `rd_row_load` with `rd_row_addr`=0, go to PRIME.
- PRIME: wait for `rd_row_rdy`, then go to SWAP.
- SWAP (1 cycle), all in the same cycle:
  - Pulse `rd_row_swap`.
  - Pulse `rd_row_load` with `rd_row_addr`=(cur_row+1) mod N_ROWS.
  - Set `plane`=0.
  - Go to SHIFT.
- SHIFT:
  - N_COLS cycles with `rd_en`=1 and `rd_col_addr`=0..N_COLS-1, one column per cycle.
  - `sh_plane` tracks `plane`, delayed with `rd_en`.
  - `frame_start` pulses on the first SHIFT cycle when cur_row=0 and plane=0.
- SETTLE: 2 cycles. Drains the shifter pipeline; `phy_blank`=1.
- LATCH: 1 cycle, `phy_le`=1, `phy_addr`<=cur_row.
- SHOW:
  - `phy_blank`=0 for max(cfg_bcm_lsb,1)<<plane cycles.
  - Timer width is 8+N_PLANES-1 bits.
  - `cfg_bcm_lsb` is sampled at SHOW entry only.
- GUARD: `phy_blank`=1 for GUARD_CYCLES cycles. Present only when the macro is enabled; otherwise skipped.
- After SHOW (and GUARD, if enabled):
  - If plane<N_PLANES-1: plane++, go to SHIFT.
  - Otherwise go to NEXT.
- NEXT:
  - cur_row <= (cur_row+1) mod N_ROWS; row N_ROWS-1 wraps to 0.
  - If `ctrl_run`=0: go to DRAIN.
  - Else: wait for `rd_row_rdy`, then go to SWAP.
- DRAIN: wait for the outstanding preload's `rd_row_rdy`, set cur_row=0, go to IDLE. No load or swap is issued.
- `ctrl_run` is sampled only in IDLE and NEXT. Deassertion mid-row completes the row.
- `phy_blank`=0 only in SHOW. `phy_le` is never asserted while `phy_blank`=0.
- Synchronous reset mid-operation forces IDLE and reset values on the next edge. An in-flight readout preload is abandoned; the readout is reset alongside.

## Timing
- Per-plane cycles: N_COLS + 2 + 1 + (L<<p) [+ GUARD_CYCLES].
- Per-row overhead: SWAP 1 cycle + NEXT ≥1 cycle.
- `rd_row_rdy` low in NEXT stalls with `phy_blank`=1. No output changes while stalled.
- `rd_row_load` and `rd_row_swap` are never asserted on consecutive cycles except together in SWAP.
- The first `rd_row_load` after `ctrl_run` goes high appears one cycle later.

## Configuration
- `HUB75_SCAN_GHOST_GUARD_EN`:
  - Defined: the GUARD state inserts GUARD_CYCLES blank cycles after every SHOW.
  - Undefined: SHOW goes directly to the next SHIFT or NEXT; `GUARD_CYCLES` is ignored.

## Test plan
Params for all scenarios: N_ROWS=4, N_COLS=4, N_PLANES=2, cfg_bcm_lsb=3, model readout returning `rd_row_rdy` 5 cycles after a load.

- Reset check: hold `rst`=0 for 3 cycles with `ctrl_run`=1 -> `phy_blank`=1, all other outputs 0, no `rd_row_load`.
- Startup sequence: assert `ctrl_run` -> load(row0), then swap+load(row1), then 4 `rd_en` with col 0,1,2,3, then `sh_valid` 1 cycle later each, then one `phy_le` pulse with `phy_addr`=0, then `phy_blank` low 3 cycles (plane 0), then 6 cycles (plane 1).
- Row wrap: run 5 rows -> `phy_addr` sequence 0,1,2,3,0, `rd_row_addr` sequence 0,1,2,3,0,1, `frame_start` twice.
- Stall: delay `rd_row_rdy` by 20 cycles at a row boundary -> `phy_blank`=1 throughout, no `rd_en`, sequence resumes unchanged.
- Stop: drop `ctrl_run` mid-SHOW of row 2 -> row 2 completes, DRAIN waits for the row-3 preload's rdy, then IDLE with no further load or swap; reassert -> restart at row 0.
- Guard macro: with `HUB75_SCAN_GHOST_GUARD_EN` and GUARD_CYCLES=4 -> 4 blank cycles after each SHOW; plane period grows from N_COLS+3+L<<p to N_COLS+7+L<<p.
